// File: rtl/mdu_pkg.sv
// Shared definitions for the M-extension coprocessor: opcode constants,
// divide funct3 encodings and the divider-controller state type.
package mdu_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    F3_DIV  = 3'b100,
    F3_DIVU = 3'b101,
    F3_REM  = 3'b110,
    F3_REMU = 3'b111
  } div_funct3_e;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    COOL
  } div_state_e;

endpackage

// File: rtl/mdu_insn_decode.sv
// Combinational decode of an M-extension divide instruction.
// It is shared with the MUL path, which ignores the divide flags.
module mdu_insn_decode
  import mdu_pkg::*;
(
  input  logic [31:0] insn,
  output logic        is_div,
  output logic        is_unsigned,
  output logic        is_rem
);

  logic unused_insn_bits;

  assign is_div      = (insn[6:0] == OPC_OP) && (insn[31:25] == F7_MULDIV) && insn[14];
  assign is_unsigned = insn[12];
  assign is_rem      = insn[13];

  // Register fields are not needed to classify the instruction.
  assign unused_insn_bits = ^{insn[24:15], insn[11:7]};

endmodule

// File: rtl/pcpi_div_ctrl.sv
// PCPI initiator for the non-restoring divider. It keeps a one-entry
// quotient/remainder cache so that a paired DIV/REM skips the second divide.
module pcpi_div_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcpi_valid,
  input  logic [31:0]      pcpi_insn,
  input  logic [WIDTH-1:0] pcpi_rs1,
  input  logic [WIDTH-1:0] pcpi_rs2,
  output logic             pcpi_wr,
  output logic [WIDTH-1:0] pcpi_rd,
  output logic             pcpi_wait,
  output logic             pcpi_ready,
  output logic             div_start,
  output logic             div_unsigned,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  input  logic             div_done
);

  div_state_e       state;
  logic             is_div;
  logic             is_unsigned;
  logic             is_rem;
  logic             is_rem_q;
  logic             done_seen_low;
  logic             abort_q;
  logic             cache_valid;
  logic             cache_uns;
  logic [WIDTH-1:0] cache_a;
  logic [WIDTH-1:0] cache_b;
  logic [WIDTH-1:0] cache_q;
  logic [WIDTH-1:0] cache_r;
  logic             cache_hit;

  mdu_insn_decode u_decode (
    .insn        (pcpi_insn),
    .is_div      (is_div),
    .is_unsigned (is_unsigned),
    .is_rem      (is_rem)
  );

  assign cache_hit = CACHE_EN && cache_valid && (pcpi_rs1 == cache_a) &&
                     (pcpi_rs2 == cache_b) && (is_unsigned == cache_uns);

  // done_seen_low guards against a divider that still holds done from the previous op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      pcpi_wr       <= 1'b0;
      pcpi_rd       <= '0;
      pcpi_wait     <= 1'b0;
      pcpi_ready    <= 1'b0;
      div_start     <= 1'b0;
      div_unsigned  <= 1'b0;
      div_a         <= '0;
      div_b         <= '0;
      is_rem_q      <= 1'b0;
      done_seen_low <= 1'b0;
      abort_q       <= 1'b0;
      cache_valid   <= 1'b0;
      cache_uns     <= 1'b0;
      cache_a       <= '0;
      cache_b       <= '0;
      cache_q       <= '0;
      cache_r       <= '0;
    end else begin
      div_start  <= 1'b0;
      pcpi_ready <= 1'b0;
      pcpi_wr    <= 1'b0;
      case (state)
        IDLE: begin
          if (pcpi_valid && is_div) begin
            div_a        <= pcpi_rs1;
            div_b        <= pcpi_rs2;
            div_unsigned <= is_unsigned;
            is_rem_q     <= is_rem;
            abort_q      <= 1'b0;
            if (cache_hit) begin
              pcpi_rd    <= is_rem ? cache_r : cache_q;
              pcpi_ready <= 1'b1;
              pcpi_wr    <= 1'b1;
              state      <= RESP;
            end else begin
              div_start <= 1'b1;
              pcpi_wait <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          done_seen_low <= 1'b0;
          if (!pcpi_valid) abort_q <= 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (!div_done) done_seen_low <= 1'b1;
          if (!pcpi_valid) abort_q <= 1'b1;
          if (div_done && done_seen_low) begin
            cache_valid <= 1'b1;
            cache_a     <= div_a;
            cache_b     <= div_b;
            cache_uns   <= div_unsigned;
            cache_q     <= div_q;
            cache_r     <= div_r;
            pcpi_wait   <= 1'b0;
            // A core that withdrew the request still gets the cache filled, but no response.
            if (abort_q || !pcpi_valid) begin
              state <= COOL;
            end else begin
              pcpi_rd    <= is_rem_q ? div_r : div_q;
              pcpi_ready <= 1'b1;
              pcpi_wr    <= 1'b1;
              state      <= RESP;
            end
          end
        end
        RESP:    state <= COOL;
        COOL:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcpi_div_ctrl.sv
// Directed self-checking bench for pcpi_div_ctrl with a behavioural divider
// that can either pulse done or hold it high until the next start.
module tb_pcpi_div_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pcpi_valid = 1'b0;
  logic [31:0] pcpi_insn = '0;
  logic [31:0] pcpi_rs1 = '0;
  logic [31:0] pcpi_rs2 = '0;
  logic        pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd;
  logic        div_start, div_unsigned;
  logic [31:0] div_a, div_b;

  logic        nc_wr, nc_wait, nc_ready, nc_start, nc_unsigned;
  logic [31:0] nc_rd, nc_a, nc_b;

  logic [31:0] m_q = '0, m_r = '0, m_nq = '0, m_nr = '0;
  logic        m_done = 1'b0;
  logic        m_pend = 1'b0;
  int          m_cnt = 0;
  bit          level_mode = 1'b0;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int ready_cnt = 0;
  int wr_alone_cnt = 0;
  int nc_start_cnt = 0;

  always #5 clk = ~clk;

  pcpi_div_ctrl #(.WIDTH(32), .CACHE_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready), .div_start(div_start),
    .div_unsigned(div_unsigned), .div_a(div_a), .div_b(div_b),
    .div_q(m_q), .div_r(m_r), .div_done(m_done)
  );

  pcpi_div_ctrl #(.WIDTH(32), .CACHE_EN(1'b0)) u_nocache (
    .clk(clk), .reset(reset), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(nc_wr), .pcpi_rd(nc_rd),
    .pcpi_wait(nc_wait), .pcpi_ready(nc_ready), .div_start(nc_start),
    .div_unsigned(nc_unsigned), .div_a(nc_a), .div_b(nc_b),
    .div_q(m_q), .div_r(m_r), .div_done(m_done)
  );

  function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  // RISC-V M semantics: {quotient, remainder}
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic uns);
    logic signed [31:0] sq, sr;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (uns) return {a / b, a % b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {a, 32'd0};
    sq = $signed(a) / $signed(b);
    sr = $signed(a) % $signed(b);
    return {sq, sr};
  endfunction

  // Divider model: done after 6 cycles; in level mode the old done stays high for a few cycles.
  always @(posedge clk) begin
    logic [63:0] res;
    if (div_start) begin
      res = ref_div(div_a, div_b, div_unsigned);
      m_nq   <= res[63:32];
      m_nr   <= res[31:0];
      m_cnt  <= 6;
      m_pend <= 1'b1;
      if (!level_mode) m_done <= 1'b0;
    end else if (m_pend) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_pend <= 1'b0;
        m_done <= 1'b1;
        m_q    <= m_nq;
        m_r    <= m_nr;
      end else if (m_cnt <= 3) begin
        m_done <= 1'b0;
      end
    end else if (!level_mode) begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (div_start) start_cnt++;
    if (pcpi_ready) ready_cnt++;
    if (pcpi_wr && !pcpi_ready) wr_alone_cnt++;
    if (nc_start) nc_start_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] insn,
                               input logic [31:0] rs1, input logic [31:0] rs2);
    pcpi_valid = valid;
    pcpi_insn  = insn;
    pcpi_rs1   = rs1;
    pcpi_rs2   = rs2;
  endtask

  task automatic run_op(input string tag, input logic [31:0] insn, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] exp_rd, input bit exp_hit);
    int s0, r0, cycles, wait_low;
    bit got;
    s0 = start_cnt;
    r0 = ready_cnt;
    cycles = 0;
    wait_low = 0;
    got = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, insn, rs1, rs2);
    while (!got && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (pcpi_ready) got = 1'b1;
      else if (!pcpi_wait) wait_low++;
    end
    checkOutput({tag, "_ready_seen"}, {31'd0, got}, 32'd1);
    checkOutput({tag, "_rd"}, pcpi_rd, exp_rd);
    checkOutput({tag, "_wr"}, {31'd0, pcpi_wr}, 32'd1);
    checkOutput({tag, "_wait_in_resp"}, {31'd0, pcpi_wait}, 32'd0);
    if (exp_hit) begin
      checkOutput({tag, "_hit_latency"}, cycles, 32'd1);
      checkOutput({tag, "_hit_starts"}, start_cnt - s0, 32'd0);
    end else begin
      checkOutput({tag, "_miss_starts"}, start_cnt - s0, 32'd1);
      checkOutput({tag, "_wait_gaps"}, wait_low, 32'd0);
    end
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput({tag, "_ready_pulses"}, ready_cnt - r0, 32'd1);
    checkOutput({tag, "_rd_hold"}, pcpi_rd, exp_rd);
    @(negedge clk);
  endtask

  initial begin
    int s0, r0, nc0, bad;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_outputs", {pcpi_wait, pcpi_ready, pcpi_wr, div_start, div_unsigned},
                32'd0);
    checkOutput("reset_rd", pcpi_rd, 32'd0);

    // 1: DIVU 100/7
    run_op("divu_100_7", mk_insn(F7_MULDIV, F3_DIVU, OPC_OP), 32'd100, 32'd7, 32'd14, 1'b0);
    checkOutput("divu_unsigned_flag", {31'd0, div_unsigned}, 32'd1);

    // 2: REM -7 % 2
    run_op("rem_m7_2", mk_insn(F7_MULDIV, F3_REM, OPC_OP), 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 1'b0);
    checkOutput("rem_signed_flag", {31'd0, div_unsigned}, 32'd0);

    // 3: DIV then REM on the same operands; the cache-less instance must divide again
    run_op("div_20_3", mk_insn(F7_MULDIV, F3_DIV, OPC_OP), 32'd20, 32'd3, 32'd6, 1'b0);
    nc0 = nc_start_cnt;
    run_op("rem_20_3_hit", mk_insn(F7_MULDIV, F3_REM, OPC_OP), 32'd20, 32'd3, 32'd2, 1'b1);
    checkOutput("nocache_restart", nc_start_cnt - nc0, 32'd1);

    // 4: non-divide instructions held valid get no response
    s0 = start_cnt;
    r0 = ready_cnt;
    bad = 0;
    @(negedge clk);
    applyStimulus(1'b1, mk_insn(F7_MULDIV, 3'b000, OPC_OP), 32'd5, 32'd6);
    repeat (20) begin
      @(negedge clk);
      if (pcpi_wait || pcpi_ready || pcpi_wr || div_start) bad++;
    end
    checkOutput("mul_ignored", bad, 32'd0);
    applyStimulus(1'b1, mk_insn(F7_MULDIV, F3_DIV, 7'b0010011), 32'd5, 32'd6);
    repeat (20) begin
      @(negedge clk);
      if (pcpi_wait || pcpi_ready || pcpi_wr || div_start) bad++;
    end
    checkOutput("non_op_ignored", bad, 32'd0);
    checkOutput("ignored_starts", start_cnt - s0, 32'd0);
    checkOutput("ignored_readies", ready_cnt - r0, 32'd0);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0);

    // 5: held-level done from the previous divide must not be taken
    level_mode = 1'b1;
    run_op("divu_1000_10", mk_insn(F7_MULDIV, F3_DIVU, OPC_OP), 32'd1000, 32'd10, 32'd100,
           1'b0);
    checkOutput("stale_done_high", {31'd0, m_done}, 32'd1);
    run_op("divu_9_4_stale", mk_insn(F7_MULDIV, F3_DIVU, OPC_OP), 32'd9, 32'd4, 32'd2, 1'b0);
    level_mode = 1'b0;
    repeat (2) @(negedge clk);

    // Divide by zero passes through the divider's result
    run_op("div_by_zero", mk_insn(F7_MULDIV, F3_DIV, OPC_OP), 32'd17, 32'd0,
           32'hFFFF_FFFF, 1'b0);

    // 6: reset while waiting on the divider
    @(negedge clk);
    applyStimulus(1'b1, mk_insn(F7_MULDIV, F3_DIVU, OPC_OP), 32'd50, 32'd5);
    repeat (3) @(negedge clk);
    checkOutput("pre_reset_wait", {31'd0, pcpi_wait}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0);
    checkOutput("midop_reset_outputs",
                {pcpi_wait, pcpi_ready, pcpi_wr, div_start, div_unsigned}, 32'd0);
    checkOutput("midop_reset_rd", pcpi_rd, 32'd0);
    checkOutput("midop_reset_a", div_a, 32'd0);
    checkOutput("midop_reset_b", div_b, 32'd0);
    r0 = ready_cnt;
    repeat (10) @(negedge clk);
    checkOutput("late_done_ignored", ready_cnt - r0, 32'd0);
    run_op("divu_50_5_after_reset", mk_insn(F7_MULDIV, F3_DIVU, OPC_OP), 32'd50, 32'd5,
           32'd10, 1'b0);

    checkOutput("wr_without_ready", wr_alone_cnt, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
